// File: rtl/ftsd_pkg.sv
// Shared constants and helpers for the seven-segment scan engine.
package ftsd_pkg;

  localparam int unsigned FTSD_N_DIGITS             = 4;
  localparam int unsigned FTSD_DW                   = 3;
  localparam int unsigned FTSD_PRESCALE_100HZ       = 50000;
  localparam int unsigned FTSD_BLANK_DEFAULT        = 500;
  localparam int unsigned FTSD_BLINK_FRAMES_DEFAULT = 64;
  localparam int unsigned FTSD_MAX_DIGITS           = 32;

  // Active-low anode select: digit idx of n drives bit n-1-idx low.
  function automatic logic [FTSD_MAX_DIGITS-1:0] anode_onehot_n(input int unsigned idx,
                                                                input int unsigned n);
    return ~(FTSD_MAX_DIGITS'(1) << (n - 1 - idx));
  endfunction

endpackage

// File: rtl/ftsd_scan_engine_if.sv
// Producer-facing bus of the scan engine: digit codes and controls in, anode/code drive out.
interface ftsd_scan_engine_if import ftsd_pkg::*; #(
  parameter int unsigned N_DIGITS = FTSD_N_DIGITS,
  parameter int unsigned DW       = FTSD_DW
) ();

  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic                   en;
  logic [N_DIGITS*DW-1:0] digits;
  logic [N_DIGITS-1:0]    dig_en;
  logic [N_DIGITS-1:0]    blink;
  logic [N_DIGITS-1:0]    ftsd_ctl;
  logic [DW-1:0]          ftsd;
  logic [IW-1:0]          digit_idx;
  logic                   frame_start;

  modport master (
    output en, digits, dig_en, blink,
    input  ftsd_ctl, ftsd, digit_idx, frame_start
  );

  modport slave (
    input  en, digits, dig_en, blink,
    output ftsd_ctl, ftsd, digit_idx, frame_start
  );

endinterface

// File: rtl/ftsd_prescaler.sv
// Modulo-MOD counter with synchronous clear; exposes its next value and a wrap strobe.
module ftsd_prescaler #(
  parameter int unsigned MOD = 2,
  parameter int unsigned W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count_next_c,
  output logic         tc_c
);

  logic [W-1:0] count;

  always_comb begin
    tc_c         = inc && !clr && (count == W'(MOD - 1));
    count_next_c = count;
    if (clr || tc_c) begin
      count_next_c = '0;
    end else if (inc) begin
      count_next_c = count + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= count_next_c;
  end

endmodule

// File: rtl/ftsd_scan_engine.sv
// Self-timed seven-segment multiplexer: slot timing, frame snapshot, ghost blanking and blink.
// Output registers are loaded from next-state so they line up with the counters they describe.
module ftsd_scan_engine import ftsd_pkg::*; #(
  parameter int unsigned N_DIGITS     = FTSD_N_DIGITS,
  parameter int unsigned DW           = FTSD_DW,
  parameter int unsigned PRESCALE     = FTSD_PRESCALE_100HZ,
  parameter int unsigned BLANK_CYCLES = FTSD_BLANK_DEFAULT,
  parameter int unsigned BLINK_FRAMES = FTSD_BLINK_FRAMES_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  ftsd_scan_engine_if.slave  bus
);

  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned CW = $clog2(PRESCALE);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic                         running, running_n;
  logic [IW-1:0]                idx, idx_n;
  logic                         phase, phase_n;
  logic [N_DIGITS-1:0][DW-1:0]  shadow, shadow_n;
  logic [CW-1:0]                cnt_n;
  logic [FW-1:0]                frame_cnt_unused;
  logic                         clr, slot_tc, frame_tc, last_slot, frame_wrap, lit;
  logic [N_DIGITS-1:0]          ctl_q, ctl_n;
  logic [DW-1:0]                ftsd_q, ftsd_n;
  logic                         fs_q, fs_n;

  // Disabled, or first enabled edge: restart the scan at slot 0, cnt 0.
  assign clr        = !bus.en || !running;
  assign last_slot  = (idx == IW'(N_DIGITS - 1));
  assign frame_wrap = slot_tc && last_slot;

  ftsd_prescaler #(.MOD(PRESCALE), .W(CW)) u_slot (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .inc          (1'b1),
    .count_next_c (cnt_n),
    .tc_c         (slot_tc)
  );

  ftsd_prescaler #(.MOD(BLINK_FRAMES), .W(FW)) u_frame (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .inc          (frame_wrap),
    .count_next_c (frame_cnt_unused),
    .tc_c         (frame_tc)
  );

  // Next-state: slot index, blink phase, frame snapshot.
  always_comb begin
    idx_n     = idx;
    phase_n   = phase;
    shadow_n  = shadow;
    running_n = bus.en;
    if (clr) begin
      idx_n   = '0;
      phase_n = 1'b0;
    end else begin
      if (slot_tc)  idx_n   = last_slot ? '0 : idx + IW'(1);
      if (frame_tc) phase_n = ~phase;
    end
    if ((bus.en && !running) || frame_wrap) shadow_n = bus.digits;
  end

  // Output values derived from next-state; enable and blink masks are taken live.
  always_comb begin
    lit    = bus.en && (cnt_n >= CW'(BLANK_CYCLES)) && bus.dig_en[idx_n] &&
             !(bus.blink[idx_n] && phase_n);
    ctl_n  = lit ? N_DIGITS'(anode_onehot_n(32'(idx_n), N_DIGITS)) : '1;
    fs_n   = bus.en && (idx_n == '0) && (cnt_n == '0);
    ftsd_n = shadow_n[idx_n];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      idx     <= '0;
      phase   <= 1'b0;
      shadow  <= '0;
      ctl_q   <= '1;
      ftsd_q  <= '0;
      fs_q    <= 1'b0;
    end else begin
      running <= running_n;
      idx     <= idx_n;
      phase   <= phase_n;
      shadow  <= shadow_n;
      ctl_q   <= ctl_n;
      ftsd_q  <= ftsd_n;
      fs_q    <= fs_n;
    end
  end

  assign bus.ftsd_ctl    = ctl_q;
  assign bus.ftsd        = ftsd_q;
  assign bus.digit_idx   = idx;
  assign bus.frame_start = fs_q;

endmodule
